// File: rtl/connect4_pkg.sv
// connect4_pkg: Connect-4 board geometry, tile codes, board type and drop FSM states.
// Shared by board_state_ctrl and the screen drawer that renders the tile array.
package connect4_pkg;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int CELLS = ROWS * COLS;

  typedef enum logic [1:0] {
    TILE_EMPTY = 2'd0,
    TILE_P1    = 2'd1,
    TILE_P2    = 2'd2
  } tile_t;

  // Row 0 is the top of the screen, column 0 the left edge.
  typedef tile_t [0:ROWS-1][0:COLS-1] board_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FALL,
    ST_COMMIT,
    ST_ERR,
    ST_DONE
  } drop_state_t;

  function automatic board_t empty_board();
    board_t b;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        b[r[2:0]][c[2:0]] = TILE_EMPTY;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/board_state_ctrl_if.sv
// board_state_ctrl_if: column-drop request/response handshake between a move source
// (master) and the board controller (slave).
interface board_state_ctrl_if;

  logic       drop_valid;
  logic [2:0] drop_col;
  logic       drop_ready;
  logic       drop_done;
  logic       drop_err;

  modport master (
    output drop_valid, drop_col,
    input  drop_ready, drop_done, drop_err
  );

  modport slave (
    input  drop_valid, drop_col,
    output drop_ready, drop_done, drop_err
  );

endinterface

// File: rtl/tile_overlay.sv
// tile_overlay: merges the falling token into the board image for display.
// Only present when DROP_ANIM_EN is defined.
`ifdef DROP_ANIM_EN
module tile_overlay
  import connect4_pkg::*;
(
  input  board_t     board,
  input  logic       overlay_en,
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  tile_t      player,
  output board_t     merged
);

  // Cells above the landing row are always empty, so painting the token over them is the same as OR-ing it in.
  always_comb begin
    merged = board;
    if (overlay_en) begin
      merged[row][col] = player;
    end
  end

endmodule
`endif

// File: rtl/board_state_ctrl.sv
// board_state_ctrl: owns the Connect-4 board, accepts column drops, finds the landing row
// with a one-row-per-cycle gravity scan, commits the token and alternates players.
// Optional feature macro: DROP_ANIM_EN adds a frame_tick driven falling-token animation.
module board_state_ctrl
  import connect4_pkg::*;
#(
  parameter int FALL_TICKS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     new_game,
  board_state_ctrl_if.slave        drop_if,
  input  logic                     frame_tick,
  output board_t                   tiles,
  output logic [1:0]               cur_player,
  output logic [5:0]               move_count,
  output logic                     board_full
);

  drop_state_t state;
  board_t      board;
  tile_t       player;
  logic [5:0]  count_q;
  logic [2:0]  col_q;
  logic [2:0]  row_ptr;
  logic [2:0]  land_row;
  logic        done_q;
  logic        err_q;

`ifdef DROP_ANIM_EN
  logic [2:0]  fall_row;
  logic [7:0]  tick_cnt;
  logic        overlay_en;
  board_t      merged;
  board_t      tiles_q;
`endif

  assign drop_if.drop_ready = (state == ST_IDLE) && !new_game;
  assign drop_if.drop_done  = done_q;
  assign drop_if.drop_err   = err_q;
  assign cur_player         = player;
  assign move_count         = count_q;
  assign board_full         = (count_q == 6'(CELLS));

  // Drop FSM: accept, scan upward from the bottom, optionally animate, commit, then pulse the result.
  // ST_COMMIT and ST_ERR each load their result pulse so it is visible while in ST_DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      board    <= empty_board();
      player   <= TILE_P1;
      count_q  <= '0;
      col_q    <= '0;
      row_ptr  <= '0;
      land_row <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef DROP_ANIM_EN
      fall_row <= '0;
      tick_cnt <= '0;
`endif
    end else if (new_game) begin
      state    <= ST_IDLE;
      board    <= empty_board();
      player   <= TILE_P1;
      count_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef DROP_ANIM_EN
      fall_row <= '0;
      tick_cnt <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (drop_if.drop_valid) begin
            col_q   <= drop_if.drop_col;
            row_ptr <= 3'(ROWS - 1);
            state   <= (drop_if.drop_col >= 3'(COLS)) ? ST_ERR : ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (board[row_ptr][col_q] == TILE_EMPTY) begin
            land_row <= row_ptr;
`ifdef DROP_ANIM_EN
            fall_row <= '0;
            tick_cnt <= '0;
            state    <= ST_FALL;
`else
            state    <= ST_COMMIT;
`endif
          end else if (row_ptr != 3'd0) begin
            row_ptr <= row_ptr - 3'd1;
          end else begin
            state <= ST_ERR;
          end
        end
`ifdef DROP_ANIM_EN
        ST_FALL: begin
          if (fall_row == land_row) begin
            state <= ST_COMMIT;
          end else if (frame_tick) begin
            if (tick_cnt == 8'(FALL_TICKS - 1)) begin
              tick_cnt <= '0;
              fall_row <= fall_row + 3'd1;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end
`endif
        ST_COMMIT: begin
          board[land_row][col_q] <= player;
          player <= (player == TILE_P1) ? TILE_P2 : TILE_P1;
          if (count_q != 6'(CELLS)) begin
            count_q <= count_q + 6'd1;
          end
          done_q <= 1'b1;
          state  <= ST_DONE;
        end
        ST_ERR: begin
          err_q <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DROP_ANIM_EN
  assign overlay_en = (state == ST_FALL) || (state == ST_COMMIT);

  tile_overlay u_overlay (
    .board      (board),
    .overlay_en (overlay_en),
    .row        (fall_row),
    .col        (col_q),
    .player     (player),
    .merged     (merged)
  );

  // Register the merged image so the display sees a glitch-free board; new_game drops the overlay at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tiles_q <= empty_board();
    end else if (new_game) begin
      tiles_q <= empty_board();
    end else begin
      tiles_q <= merged;
    end
  end

  assign tiles = tiles_q;
`else
  logic unused_anim;
  assign unused_anim = frame_tick ^ (FALL_TICKS > 0);
  assign tiles       = board;
`endif

endmodule

// File: tb/tb_board_state_ctrl.sv
// tb_board_state_ctrl: directed self-checking bench for board_state_ctrl.
// Runs in the default build; with DROP_ANIM_EN defined it also exercises the falling-token overlay.
module tb_board_state_ctrl;
  import connect4_pkg::*;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       new_game   = 1'b0;
  logic       frame_tick = 1'b1;
  board_t     tiles;
  logic [1:0] cur_player;
  logic [5:0] move_count;
  logic       board_full;
  board_t     exp_b;
  int         total = 0;
  int         bad   = 0;

  board_state_ctrl_if bus ();

  board_state_ctrl #(.FALL_TICKS(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .drop_if    (bus),
    .frame_tick (frame_tick),
    .tiles      (tiles),
    .cur_player (cur_player),
    .move_count (move_count),
    .board_full (board_full)
  );

  always #5 clk = ~clk;

  // Cycle (accept edge = 0) in which drop_done shows for a column holding k tokens.
  // With the animation and frame_tick held high: k+1 scan cycles, 5-k fall steps, commit, done.
`ifdef DROP_ANIM_EN
  function automatic int done_cycle(input int k);
    return (k + 1) + (5 - k) + 2;
  endfunction
`else
  function automatic int done_cycle(input int k);
    return k + 2;
  endfunction
`endif

  task automatic clear_exp();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        exp_b[r[2:0]][c[2:0]] = TILE_EMPTY;
      end
    end
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    @(negedge clk);
  endtask

  // Issue one drop from a ready negedge; report the pulse cycle and kind, end on the cycle after it.
  task automatic do_drop(input logic [2:0] col, output int cyc, output bit got_done, output bit got_err);
    cyc = -1;
    got_done = 1'b0;
    got_err = 1'b0;
    bus.drop_valid = 1'b1;
    bus.drop_col = col;
    @(negedge clk);
    bus.drop_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.drop_done || bus.drop_err) begin
        cyc = n;
        got_done = bus.drop_done;
        got_err = bus.drop_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int cyc;
    bit d, e, seen;
    bus.drop_valid = 1'b0;
    bus.drop_col = 3'd0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (move_count !== 6'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", move_count); end
    total++; if (cur_player !== 2'd1) begin bad++; $display("FAIL reset_player: got %0d want 1", cur_player); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.drop_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.drop_ready); end
    total++; if ({bus.drop_done, bus.drop_err, board_full} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {bus.drop_done, bus.drop_err, board_full}); end
    do_drop(3'd3, cyc, d, e);
    total++; if (move_count !== 6'd1) begin bad++; $display("FAIL pre_reset_commit: got %0d want 1", move_count); end
    bus.drop_valid = 1'b1;
    bus.drop_col = 3'd3;
    @(negedge clk);
    bus.drop_valid = 1'b0;
    reset = 1'b0;
    #1;
    clear_exp();
    total++; if (tiles !== exp_b) begin bad++; $display("FAIL midscan_reset_tiles: got %h want %h", tiles, exp_b); end
    total++; if (move_count !== 6'd0) begin bad++; $display("FAIL midscan_reset_count: got %0d want 0", move_count); end
    total++; if (cur_player !== 2'd1) begin bad++; $display("FAIL midscan_reset_player: got %0d want 1", cur_player); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.drop_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b want 1", bus.drop_ready); end
    seen = 1'b0;
    repeat (4) begin
      if (bus.drop_done || bus.drop_err) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL aborted_pulse: got %b want 0", seen); end
  endtask

  task automatic test_first_drop();
    int cyc;
    bit d, e;
    do_drop(3'd0, cyc, d, e);
    clear_exp();
    exp_b[5][0] = TILE_P1;
    total++; if (cyc !== done_cycle(0)) begin bad++; $display("FAIL first_latency: got %0d want %0d", cyc, done_cycle(0)); end
    total++; if ({d, e} !== 2'b10) begin bad++; $display("FAIL first_pulse: got %b want 10", {d, e}); end
    total++; if (tiles[5][0] !== TILE_P1) begin bad++; $display("FAIL first_cell: got %0d want 1", tiles[5][0]); end
    total++; if (tiles !== exp_b) begin bad++; $display("FAIL first_board: got %h want %h", tiles, exp_b); end
    total++; if (cur_player !== 2'd2) begin bad++; $display("FAIL first_player: got %0d want 2", cur_player); end
    total++; if (move_count !== 6'd1) begin bad++; $display("FAIL first_count: got %0d want 1", move_count); end
    total++; if ({bus.drop_ready, bus.drop_done} !== 2'b10) begin bad++; $display("FAIL first_after: got %b want 10", {bus.drop_ready, bus.drop_done}); end
  endtask

  task automatic test_column_fill();
    int cyc, rr;
    bit d, e;
    pulse_new_game();
    clear_exp();
    total++; if (tiles !== exp_b) begin bad++; $display("FAIL ng_clear_board: got %h want %h", tiles, exp_b); end
    total++; if ({cur_player, move_count} !== {2'd1, 6'd0}) begin bad++; $display("FAIL ng_clear_state: got %0d/%0d want 1/0", cur_player, move_count); end
    for (int i = 0; i < 6; i++) begin
      do_drop(3'd4, cyc, d, e);
      total++; if (cyc !== done_cycle(i) || d !== 1'b1) begin bad++; $display("FAIL fill_drop%0d: got cycle %0d done %b want cycle %0d done 1", i, cyc, d, done_cycle(i)); end
      rr = 5 - i;
      exp_b[rr[2:0]][4] = (i % 2 == 0) ? TILE_P1 : TILE_P2;
    end
    total++; if (tiles !== exp_b) begin bad++; $display("FAIL fill_board: got %h want %h", tiles, exp_b); end
    total++; if ({cur_player, move_count} !== {2'd1, 6'd6}) begin bad++; $display("FAIL fill_state: got %0d/%0d want 1/6", cur_player, move_count); end
    do_drop(3'd4, cyc, d, e);
    total++; if (cyc !== 7) begin bad++; $display("FAIL full_col_latency: got %0d want 7", cyc); end
    total++; if ({d, e} !== 2'b01) begin bad++; $display("FAIL full_col_pulse: got %b want 01", {d, e}); end
    total++; if (tiles !== exp_b) begin bad++; $display("FAIL full_col_board: got %h want %h", tiles, exp_b); end
    total++; if ({cur_player, move_count} !== {2'd1, 6'd6}) begin bad++; $display("FAIL full_col_state: got %0d/%0d want 1/6", cur_player, move_count); end
  endtask

  task automatic test_invalid_hold();
    int cyc, pulses, pulse_at;
    bit d, e;
    do_drop(3'd7, cyc, d, e);
    total++; if (cyc !== 1) begin bad++; $display("FAIL bad_col_latency: got %0d want 1", cyc); end
    total++; if ({d, e} !== 2'b01) begin bad++; $display("FAIL bad_col_pulse: got %b want 01", {d, e}); end
    total++; if (tiles !== exp_b) begin bad++; $display("FAIL bad_col_board: got %h want %h", tiles, exp_b); end
    total++; if (move_count !== 6'd6) begin bad++; $display("FAIL bad_col_count: got %0d want 6", move_count); end
    pulses = 0;
    pulse_at = -1;
    bus.drop_valid = 1'b1;
    bus.drop_col = 3'd0;
    @(negedge clk);
    for (int n = 0; n < 30; n++) begin
      if (n < 3) begin
        total++; if (bus.drop_ready !== 1'b0) begin bad++; $display("FAIL hold_busy%0d: got ready %b want 0", n, bus.drop_ready); end
      end
      if (n == 3) bus.drop_valid = 1'b0;
      if (bus.drop_done) begin
        pulses++;
        if (pulse_at < 0) pulse_at = n;
      end
      @(negedge clk);
    end
    exp_b[5][0] = TILE_P1;
    total++; if (pulses !== 1) begin bad++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
    total++; if (pulse_at !== done_cycle(0)) begin bad++; $display("FAIL hold_latency: got %0d want %0d", pulse_at, done_cycle(0)); end
    total++; if (move_count !== 6'd7) begin bad++; $display("FAIL hold_count: got %0d want 7", move_count); end
    total++; if (tiles !== exp_b) begin bad++; $display("FAIL hold_board: got %h want %h", tiles, exp_b); end
    total++; if (cur_player !== 2'd2) begin bad++; $display("FAIL hold_player: got %0d want 2", cur_player); end
  endtask

  task automatic test_new_game();
    bit seen;
    seen = 1'b0;
    bus.drop_valid = 1'b1;
    bus.drop_col = 3'd1;
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    if (bus.drop_done || bus.drop_err) seen = 1'b1;
    total++; if (bus.drop_ready !== 1'b0) begin bad++; $display("FAIL ng_ready_idle: got %b want 0", bus.drop_ready); end
    @(negedge clk);
    if (bus.drop_done || bus.drop_err) seen = 1'b1;
    total++; if (bus.drop_ready !== 1'b0) begin bad++; $display("FAIL ng_ready_hold: got %b want 0", bus.drop_ready); end
    bus.drop_valid = 1'b0;
    new_game = 1'b0;
    clear_exp();
    total++; if (tiles !== exp_b) begin bad++; $display("FAIL ng_board: got %h want %h", tiles, exp_b); end
    total++; if ({cur_player, move_count} !== {2'd1, 6'd0}) begin bad++; $display("FAIL ng_state: got %0d/%0d want 1/0", cur_player, move_count); end
    @(negedge clk);
    total++; if (bus.drop_ready !== 1'b1) begin bad++; $display("FAIL ng_ready_after: got %b want 1", bus.drop_ready); end
    repeat (4) begin
      if (bus.drop_done || bus.drop_err) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL ng_pulse: got %b want 0", seen); end
  endtask

`ifdef DROP_ANIM_EN
  task automatic test_anim();
    int am1;
    bit seen;
    pulse_new_game();
    frame_tick = 1'b0;
    bus.drop_valid = 1'b1;
    bus.drop_col = 3'd2;
    @(negedge clk);
    bus.drop_valid = 1'b0;
    repeat (2) @(negedge clk);
    seen = 1'b0;
    repeat (5) begin
      if (bus.drop_done || bus.drop_err) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL anim_stall: got pulse %b want 0", seen); end
    for (int a = 0; a < 6; a++) begin
      if (a > 0) begin
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        am1 = a - 1;
        total++; if (tiles[am1[2:0]][2] !== TILE_EMPTY) begin bad++; $display("FAIL anim_leave%0d: got %0d want 0", am1, tiles[am1[2:0]][2]); end
      end
      total++; if (tiles[a[2:0]][2] !== TILE_P1) begin bad++; $display("FAIL anim_row%0d: got %0d want 1", a, tiles[a[2:0]][2]); end
      total++; if (move_count !== 6'd0) begin bad++; $display("FAIL anim_count%0d: got %0d want 0", a, move_count); end
    end
    @(negedge clk);
    total++; if (bus.drop_done !== 1'b1) begin bad++; $display("FAIL anim_done: got %b want 1", bus.drop_done); end
    @(negedge clk);
    clear_exp();
    exp_b[5][2] = TILE_P1;
    total++; if (tiles !== exp_b) begin bad++; $display("FAIL anim_board: got %h want %h", tiles, exp_b); end
    total++; if ({cur_player, move_count} !== {2'd2, 6'd1}) begin bad++; $display("FAIL anim_state: got %0d/%0d want 2/1", cur_player, move_count); end
    frame_tick = 1'b1;
  endtask
`endif

  task automatic test_board_full();
    int cyc, rr;
    bit d, e;
    pulse_new_game();
    clear_exp();
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        do_drop(c[2:0], cyc, d, e);
        total++; if (cyc !== done_cycle(r) || d !== 1'b1) begin bad++; $display("FAIL full_drop_c%0d_r%0d: got cycle %0d done %b want cycle %0d done 1", c, r, cyc, d, done_cycle(r)); end
        total++; if (board_full !== (c == 6 && r == 5)) begin bad++; $display("FAIL full_flag_c%0d_r%0d: got %b want %b", c, r, board_full, (c == 6 && r == 5)); end
        rr = 5 - r;
        exp_b[rr[2:0]][c[2:0]] = (r % 2 == 0) ? TILE_P1 : TILE_P2;
      end
    end
    total++; if (tiles !== exp_b) begin bad++; $display("FAIL full_board: got %h want %h", tiles, exp_b); end
    total++; if ({cur_player, move_count} !== {2'd1, 6'd42}) begin bad++; $display("FAIL full_state: got %0d/%0d want 1/42", cur_player, move_count); end
    do_drop(3'd3, cyc, d, e);
    total++; if (cyc !== 7 || {d, e} !== 2'b01) begin bad++; $display("FAIL full_extra: got cycle %0d pulse %b want cycle 7 pulse 01", cyc, {d, e}); end
    total++; if ({board_full, move_count} !== {1'b1, 6'd42}) begin bad++; $display("FAIL full_saturate: got %b/%0d want 1/42", board_full, move_count); end
  endtask

  initial begin
    bus.drop_valid = 1'b0;
    bus.drop_col = 3'd0;
    test_reset();
    test_first_drop();
    test_column_fill();
    test_invalid_hold();
    test_new_game();
`ifdef DROP_ANIM_EN
    test_anim();
`endif
    test_board_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
